meas_vote: RTL and testbench
============================

// Module: meas_vote
// PURPOSE
//  Temporal majority-vote stage downstream of the PUF measurement core. Triggers C_ROUNDS
//  measurement runs, accumulates per-bit counts of each raw primary ID and outputs the
//  majority ID with a valid/ready handshake. Suppresses ring-oscillator comparison noise.
// PARAMETERS
//  C_IDWIDTH   24    raw/voted ID width (matches measurement core C_OIDWIDTH)
//  C_ROUNDS    7     measurement runs per vote, 1..255, odd required
//  C_CNTWIDTH  3     per-bit counter width, = clog2(C_ROUNDS+1)
//  C_TIMEOUT   4096  max I_sclk cycles waiting for one raw ID, >=2
//  C_MARGIN    1     minority count at/above which a bit is unstable (PUF_VOTE_MASK_EN only)
// PORTS
//  I_sclk        in   1           system clock, all logic rising-edge
//  I_rst_n       in   1           synchronous reset, active-low
//  I_start       in   1           pulse: begin a vote run (ignored unless O_busy=0)
//  O_busy        out  1           high from accepted I_start until return to IDLE
//  O_meas_start  out  1           one-cycle pulse requesting one upstream measurement
//  I_id          in   C_IDWIDTH   raw primary ID from measurement core
//  I_id_valid    in   1           one-cycle pulse: I_id is complete
//  O_id          out  C_IDWIDTH   voted ID
//  O_id_valid    out  1           voted ID available; held until I_id_ready
//  I_id_ready    in   1           consumer accepts O_id
//  O_err         out  1           one-cycle pulse: round aborted on timeout
//  O_round       out  8           completed rounds in current run
// BEHAVIOUR
//  Reset (I_rst_n=0 at edge): state IDLE; all outputs 0; counters, round, timer cleared.
//  Reset mid-run aborts without O_err; no partial result is emitted.
//  FSM IDLE->REQ->WAIT->ACC->(REQ|DONE)->IDLE:
//   IDLE: I_start=1 -> clear counters, O_round=0, O_busy=1, go REQ.
//   REQ:  O_meas_start=1 for exactly this cycle; timer=0; go WAIT.
//   WAIT: I_id_valid=1 -> register I_id, go ACC. Else timer++; timer==C_TIMEOUT-1 ->
//         O_err=1 one cycle, go IDLE (O_busy=0 next cycle). Valid wins if same cycle.
//   ACC:  cnt[b] += id[b] for all b; O_round++; if O_round+1==C_ROUNDS -> DONE else REQ.
//   DONE: O_id[b] = (cnt[b] > C_ROUNDS/2), registered on DONE entry; O_id_valid=1, O_id stable
//         until cycle with I_id_ready=1 -> O_id_valid=0 next cycle, go IDLE. O_id keeps value.
//  I_start while O_busy=1 ignored; I_id_valid outside WAIT ignored.
//  I_start in the cycle DONE is left is ignored (accepted from next cycle).
//  Counters cannot overflow (<=C_ROUNDS increments, C_CNTWIDTH sized). Even C_ROUNDS: tie -> 0.
//  Latency per round: 1 (REQ) + upstream wait + 1 (ACC); voted ID valid 1 cycle after last ACC.
// CONFIGURATION
//  PUF_VOTE_MASK_EN defined: extra port O_unstable [C_IDWIDTH] out, registered with O_id;
//   bit b = 1 when min(cnt[b], C_ROUNDS-cnt[b]) >= C_MARGIN; reset 0.
//  Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  meas_pkg: FSM state localparams (IDLE=0,REQ=1,WAIT=2,ACC=3,DONE=4, 3 bits), clog2 function.
//  Sub-module meas_vote_cnt: one per-bit counter (clear, inc) + majority/unstable decode,
//   generated C_IDWIDTH times. FSM, timer, round counter stay in meas_vote.
// TESTING
//  1 C_ROUNDS=7: I_start, return I_id=24'hA5A5A5 all rounds -> 7 O_meas_start, O_id=24'hA5A5A5.
//  2 Bit0 =1 in 4 of 7 rounds, bit1 =1 in 3 of 7 -> O_id[0]=1, O_id[1]=0;
//    MASK_EN, C_MARGIN=1: O_unstable=24'h000003.
//  3 No I_id_valid after round 2 -> O_err pulse at C_TIMEOUT cycles, O_busy=0, O_id_valid=0.
//  4 Hold I_id_ready=0 for 20 cycles in DONE -> O_id_valid and O_id stable; I_start ignored.
//  5 Assert I_rst_n=0 in WAIT of round 4 -> next cycle all outputs 0, IDLE; new run clean.
//  6 Stray I_id_valid in IDLE/REQ and I_start while busy -> no count change, no restart.

Source files
------------

// File: rtl/meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : meas_pkg
// Description : Shared definitions for the temporal majority-vote stage:
//               vote FSM state encoding and a constant-evaluable clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package meas_pkg;

  // Vote sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Ceiling log2, usable in parameter/localparam context.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/meas_vote_cnt.sv
`default_nettype none
// ============================================================================
// Module      : meas_vote_cnt
// Description : One per-bit vote counter with majority (and optionally
//               instability) decode of the value the counter is about to hold,
//               so the top can register the result on the same edge as the
//               final increment.
// Ports       : clk           in  system clock
//               rst_n         in  synchronous reset, active-low
//               clr           in  clear counter to zero
//               inc           in  increment counter by one
//               maj_nxt       out majority of the next count value
//               unstable_nxt  out minority >= C_MARGIN (PUF_VOTE_MASK_EN only)
// Config      : PUF_VOTE_MASK_EN adds the unstable_nxt port and decode.
// Revision    : 1.0 - initial release
// ============================================================================
module meas_vote_cnt #(
  parameter int C_ROUNDS   = 7,
  parameter int C_CNTWIDTH = 3
`ifdef PUF_VOTE_MASK_EN
  ,
  parameter int C_MARGIN   = 1
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic maj_nxt
`ifdef PUF_VOTE_MASK_EN
  ,
  output logic unstable_nxt
`endif
);

  localparam logic [C_CNTWIDTH-1:0] c_half = C_CNTWIDTH'(C_ROUNDS / 2);

  logic [C_CNTWIDTH-1:0] r_cnt;
  logic [C_CNTWIDTH-1:0] w_cnt_nxt;

  assign w_cnt_nxt = clr ? '0 : (r_cnt + C_CNTWIDTH'(inc));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Strictly greater than half: an even-round tie resolves to 0.
  assign maj_nxt = (w_cnt_nxt > c_half);

`ifdef PUF_VOTE_MASK_EN
  localparam logic [C_CNTWIDTH-1:0] c_rounds = C_CNTWIDTH'(C_ROUNDS);
  localparam logic [C_CNTWIDTH-1:0] c_margin = C_CNTWIDTH'(C_MARGIN);

  logic [C_CNTWIDTH-1:0] w_minority;

  // The losing side of the vote is whichever count is not above half.
  assign w_minority   = maj_nxt ? (c_rounds - w_cnt_nxt) : w_cnt_nxt;
  assign unstable_nxt = (w_minority >= c_margin);
`endif

endmodule
`default_nettype wire

// File: rtl/meas_vote.sv
`default_nettype none
// ============================================================================
// Module      : meas_vote
// Description : Temporal majority-vote stage behind the PUF measurement core.
//               Requests C_ROUNDS measurements, counts ones per ID bit and
//               presents the per-bit majority ID with a valid/ready handshake.
// Ports       : I_sclk        in  system clock
//               I_rst_n       in  synchronous reset, active-low
//               I_start       in  begin a vote run (only while idle)
//               O_busy        out run in progress
//               O_meas_start  out one-cycle measurement request
//               I_id          in  raw ID from measurement core
//               I_id_valid    in  one-cycle raw ID strobe
//               O_id          out voted ID
//               O_id_valid    out voted ID available until I_id_ready
//               I_id_ready    in  consumer accepts O_id
//               O_err         out one-cycle timeout abort pulse
//               O_round       out completed rounds in current run
//               O_unstable    out per-bit instability flags (PUF_VOTE_MASK_EN)
// Config      : PUF_VOTE_MASK_EN adds O_unstable.
// Revision    : 1.0 - initial release
// ============================================================================
module meas_vote
  import meas_pkg::*;
#(
  parameter int C_IDWIDTH  = 24,
  parameter int C_ROUNDS   = 7,
  parameter int C_CNTWIDTH = 3,
  parameter int C_TIMEOUT  = 4096,
  parameter int C_MARGIN   = 1
) (
  input  logic                 I_sclk,
  input  logic                 I_rst_n,
  input  logic                 I_start,
  output logic                 O_busy,
  output logic                 O_meas_start,
  input  logic [C_IDWIDTH-1:0] I_id,
  input  logic                 I_id_valid,
  output logic [C_IDWIDTH-1:0] O_id,
  output logic                 O_id_valid,
  input  logic                 I_id_ready,
  output logic                 O_err,
  output logic [7:0]           O_round
`ifdef PUF_VOTE_MASK_EN
  ,
  output logic [C_IDWIDTH-1:0] O_unstable
`endif
);

  localparam int              c_tw     = (clog2(C_TIMEOUT) < 1) ? 1 : clog2(C_TIMEOUT);
  localparam logic [c_tw-1:0] c_tmax   = c_tw'(C_TIMEOUT - 1);
  localparam logic [7:0]      c_rounds = 8'(C_ROUNDS);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_tw-1:0]        r_timer;
  logic [7:0]             r_round;
  logic [C_IDWIDTH-1:0]   r_id_raw;
  logic [C_IDWIDTH-1:0]   r_id_out;
  logic [C_IDWIDTH-1:0]   w_maj;
  logic                   w_clr;
  logic                   w_inc_en;
  logic                   w_last;

  assign w_clr    = (r_state == ST_IDLE) && I_start;
  assign w_inc_en = (r_state == ST_ACC);
  assign w_last   = ((r_round + 8'd1) == c_rounds);

  // --------------------------------------------------------------------------
  // Per-bit vote counters
  // --------------------------------------------------------------------------
`ifdef PUF_VOTE_MASK_EN
  logic [C_IDWIDTH-1:0] w_unst;
  logic [C_IDWIDTH-1:0] r_unst;
`endif

  for (genvar b = 0; b < C_IDWIDTH; b++) begin : g_bit
    meas_vote_cnt #(
      .C_ROUNDS   (C_ROUNDS),
      .C_CNTWIDTH (C_CNTWIDTH)
`ifdef PUF_VOTE_MASK_EN
      ,
      .C_MARGIN   (C_MARGIN)
`endif
    ) u_cnt (
      .clk          (I_sclk),
      .rst_n        (I_rst_n),
      .clr          (w_clr),
      .inc          (w_inc_en & r_id_raw[b]),
      .maj_nxt      (w_maj[b])
`ifdef PUF_VOTE_MASK_EN
      ,
      .unstable_nxt (w_unst[b])
`endif
    );
  end

`ifndef PUF_VOTE_MASK_EN
  // The margin only shapes the instability flags, which this build omits.
  if (C_MARGIN < 0) begin : g_no_mask
  end
`endif

  // --------------------------------------------------------------------------
  // Sequencer: next state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    O_meas_start = 1'b0;
    O_err        = 1'b0;
    O_busy       = (r_state != ST_IDLE);
    O_id_valid   = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (I_start) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        O_meas_start = 1'b1;
        w_state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        // A raw ID arriving on the final timer cycle still counts.
        if (I_id_valid) begin
          w_state_nxt = ST_ACC;
        end else if (r_timer == c_tmax) begin
          O_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACC: begin
        w_state_nxt = w_last ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        if (I_id_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer: registers
  // --------------------------------------------------------------------------
  always_ff @(posedge I_sclk) begin
    if (!I_rst_n) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_round  <= '0;
      r_id_raw <= '0;
      r_id_out <= '0;
`ifdef PUF_VOTE_MASK_EN
      r_unst   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (I_start) r_round <= '0;
        end
        ST_REQ: begin
          r_timer <= '0;
        end
        ST_WAIT: begin
          if (I_id_valid) begin
            r_id_raw <= I_id;
          end else begin
            r_timer <= r_timer + c_tw'(1);
          end
        end
        ST_ACC: begin
          r_round <= r_round + 8'd1;
          // Decode uses the post-increment counts, so the result is ready
          // on the same edge that enters DONE.
          if (w_last) begin
            r_id_out <= w_maj;
`ifdef PUF_VOTE_MASK_EN
            r_unst   <= w_unst;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign O_id    = r_id_out;
  assign O_round = r_round;
`ifdef PUF_VOTE_MASK_EN
  assign O_unstable = r_unst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_meas_vote.sv
`default_nettype none
// ============================================================================
// Module      : tb_meas_vote
// Description : Self-checking bench for meas_vote. A table of seven-round
//               raw-ID sequences with hand-computed votes, plus directed
//               sequences for timeout, held result, mid-run reset and stray
//               inputs. Honours PUF_VOTE_MASK_EN for O_unstable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_meas_vote;

  typedef logic [23:0] id_t;

  typedef struct packed {
    logic [6:0][23:0] ids;
    id_t              exp_id;
    id_t              exp_unst;
    int               dly;
    bit               stray;
  } vec_t;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic meas_start;
  id_t  id_in;
  logic id_in_valid;
  id_t  id_out;
  logic id_out_valid;
  logic id_ready;
  logic err;
  logic [7:0] round;
`ifdef PUF_VOTE_MASK_EN
  id_t  unstable;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_meas   = 0;

  vec_t vecs[5];

  meas_vote #(
    .C_IDWIDTH  (24),
    .C_ROUNDS   (7),
    .C_CNTWIDTH (3),
    .C_TIMEOUT  (4096),
    .C_MARGIN   (1)
  ) dut (
    .I_sclk       (clk),
    .I_rst_n      (rst_n),
    .I_start      (start),
    .O_busy       (busy),
    .O_meas_start (meas_start),
    .I_id         (id_in),
    .I_id_valid   (id_in_valid),
    .O_id         (id_out),
    .O_id_valid   (id_out_valid),
    .I_id_ready   (id_ready),
    .O_err        (err),
    .O_round      (round)
`ifdef PUF_VOTE_MASK_EN
    ,
    .O_unstable   (unstable)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_start) n_meas <= n_meas + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for a measurement request; returns 0 if none appears.
  task automatic wait_meas(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (meas_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Answers one measurement request after dly WAIT cycles.
  task automatic answer(input id_t v, input int dly, input bit stray, output bit ok);
    wait_meas(ok);
    if (stray) begin
      id_in       = 24'hFFFFFF;
      id_in_valid = 1'b1;
      start       = 1'b1;
    end
    @(negedge clk);
    id_in_valid = 1'b0;
    start       = 1'b0;
    if (dly > 1) repeat (dly - 1) @(negedge clk);
    id_in       = v;
    id_in_valid = 1'b1;
    @(negedge clk);
    id_in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vote(input vec_t v, output bit ok, output int meas);
    int base;
    bit r_ok;
    base = n_meas;
    ok   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 7; r++) begin
      answer(v.ids[r], v.dly, v.stray, r_ok);
      if (!r_ok) ok = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (id_out_valid) break;
      @(negedge clk);
    end
    if (!id_out_valid) ok = 1'b0;
    meas = n_meas - base;
  endtask

  task automatic check_result(input vec_t v, input string tag);
    bit ok;
    int meas;
    run_vote(v, ok, meas);
    check({tag, " done_in_bound"}, 32'(ok), 32'd1);
    check({tag, " id"}, 32'(id_out), 32'(v.exp_id));
    check({tag, " round"}, 32'(round), 32'd7);
    check({tag, " meas_starts"}, 32'(meas), 32'd7);
`ifdef PUF_VOTE_MASK_EN
    check({tag, " unstable"}, 32'(unstable), 32'(v.exp_unst));
`endif
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    check({tag, " valid_after_ack"}, 32'(id_out_valid), 32'd0);
    check({tag, " busy_after_ack"}, 32'(busy), 32'd0);
    check({tag, " id_hold_after_ack"}, 32'(id_out), 32'(v.exp_id));
  endtask

  initial begin
    bit   ok;
    int   k;
    int   base;
    id_t  held;
    bit   stable;
    vec_t v_clean;

    vecs[0].ids = {7{24'hA5A5A5}};
    vecs[0].exp_id = 24'hA5A5A5; vecs[0].exp_unst = 24'h000000; vecs[0].dly = 1; vecs[0].stray = 1'b0;
    vecs[1].ids = {24'h0, 24'h0, 24'h0, 24'h1, 24'h3, 24'h3, 24'h3};
    vecs[1].exp_id = 24'h000001; vecs[1].exp_unst = 24'h000003; vecs[1].dly = 2; vecs[1].stray = 1'b0;
    vecs[2].ids = {24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF};
    vecs[2].exp_id = 24'hFFFFFF; vecs[2].exp_unst = 24'hFFFFFF; vecs[2].dly = 3; vecs[2].stray = 1'b0;
    vecs[3].ids = {{3{24'hF0F0F0}}, {4{24'h0F0F0F}}};
    vecs[3].exp_id = 24'h0F0F0F; vecs[3].exp_unst = 24'hFFFFFF; vecs[3].dly = 1; vecs[3].stray = 1'b0;
    vecs[4].ids = {{4{24'h000000}}, {3{24'hFFFFFF}}};
    vecs[4].exp_id = 24'h000000; vecs[4].exp_unst = 24'hFFFFFF; vecs[4].dly = 2; vecs[4].stray = 1'b1;

    rst_n = 1'b0; start = 1'b0; id_in = '0; id_in_valid = 1'b0; id_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset busy", 32'(busy), 32'd0);
    check("reset meas_start", 32'(meas_start), 32'd0);
    check("reset id_valid", 32'(id_out_valid), 32'd0);
    check("reset id", 32'(id_out), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset round", 32'(round), 32'd0);

    // Stray raw ID while idle must neither start nor count.
    id_in = 24'hFFFFFF; id_in_valid = 1'b1;
    @(negedge clk);
    id_in_valid = 1'b0;
    check("stray idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) begin
      check_result(vecs[i], $sformatf("vec%0d", i));
    end

    // Result held for 20 cycles with consumer stalled and restarts attempted.
    run_vote(vecs[0], ok, k);
    check("hold done_in_bound", 32'(ok), 32'd1);
    held   = id_out;
    base   = n_meas;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      @(negedge clk);
      if (!id_out_valid || id_out !== held) stable = 1'b0;
    end
    start = 1'b0;
    check("hold stable", 32'(stable), 32'd1);
    check("hold id", 32'(held), 32'hA5A5A5);
    check("hold no_restart", 32'(n_meas - base), 32'd0);
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    check("hold valid_after_ack", 32'(id_out_valid), 32'd0);

    // Timeout after two answered rounds.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    answer(24'h123456, 1, 1'b0, ok);
    answer(24'h123456, 1, 1'b0, ok);
    wait_meas(ok);
    check("timeout req_seen", 32'(ok), 32'd1);
    k = 0;
    stable = 1'b1;
    while (k < 5000) begin
      @(negedge clk);
      k++;
      if (id_out_valid) stable = 1'b0;
      if (err) break;
    end
    check("timeout cycles", 32'(k), 32'd4096);
    check("timeout no_valid", 32'(stable), 32'd1);
    @(negedge clk);
    check("timeout err_one_cycle", 32'(err), 32'd0);
    check("timeout busy", 32'(busy), 32'd0);
    check("timeout id_valid", 32'(id_out_valid), 32'd0);

    // Reset during WAIT of round 4.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 3; r++) answer(24'hFFFFFF, 1, 1'b0, ok);
    wait_meas(ok);
    @(negedge clk);
    check("midreset in_wait busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset round", 32'(round), 32'd0);
    check("midreset id", 32'(id_out), 32'd0);
    check("midreset id_valid", 32'(id_out_valid), 32'd0);
    check("midreset err", 32'(err), 32'd0);
    check("midreset meas_start", 32'(meas_start), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    v_clean.ids = {{4{24'h000000}}, {3{24'hFFFFFF}}};
    v_clean.exp_id = 24'h000000; v_clean.exp_unst = 24'hFFFFFF; v_clean.dly = 1; v_clean.stray = 1'b0;
    check_result(v_clean, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
